poly_negacyclic_mac: RTL and testbench
======================================

# poly_negacyclic_mac

Parametrised streaming polynomial multiplier-accumulator for the LWE/Ring-LWE datapath: computes B = A·s mod (x^N + 1) mod 2^Q_BITS. Public-key coefficients A and secret coefficients s arrive LANES per beat and are multiplied chunk-by-chunk into an on-chip N-coefficient accumulator. The finished polynomial drains LANES coefficients per beat to the downstream encrypt/decrypt stage. It replaces the fixed 4×4, 6-bit, binary-secret partial multiplier with full-polynomial accumulation, wrap-around reduction, backpressure and generic widths.

## Interface
- N, 784, polynomial length in coefficients; N % LANES == 0, N >= 2*LANES
- LANES, 4, coefficients per beat on every stream
- Q_BITS, 6, coefficient width; modulus q = 2^Q_BITS
- S_BITS, 1, secret coefficient width (unsigned)
- CW, $clog2(N), coefficient index width (derived)

- clk_in  input  1  clock; single clock domain
- rst_in  input  1  synchronous, active-low reset
- a_valid  input  1  A chunk valid
- a_ready  output  1  A chunk accepted when a_valid && a_ready
- a_data  input  LANES*Q_BITS  A coefficients; lane 0 in LSBs
- s_valid  input  1  s chunk valid
- s_ready  output  1  s chunk accepted when s_valid && s_ready
- s_data  input  LANES*S_BITS  s coefficients; lane 0 in LSBs
- b_valid  output  1  result chunk valid
- b_ready  input  1  downstream accepts result chunk
- b_data  output  LANES*Q_BITS  result coefficients; lane 0 in LSBs
- b_idx  output  CW  coefficient index of lane 0 of b_data
- b_last  output  1  final result chunk
- busy  output  1  high in MAC or DRAIN

## Operation
- Order: A chunk i (0..N/LANES-1) is loaded, then all s chunks j = 0..N/LANES-1 are streamed against it; repeat for every i; then drain.
- States: LOAD_A (a_ready=1) -> on A handshake -> MAC (s_ready=1, A held). In MAC each s handshake increments s_cnt; on handshake with s_cnt == N/LANES-1: if a_cnt == N/LANES-1 -> DRAIN, else a_cnt++ -> LOAD_A. DRAIN: b_valid=1; each b handshake increments b_cnt; handshake with b_last -> LOAD_A, counters zero.
- MAC update per s beat: for lanes p, r in 0..LANES-1, term = (A[p]·s[r]) truncated to Q_BITS; k = i*LANES+p + j*LANES+r; if k < N, acc[k] += term; else acc[k-N] -= term. All LANES² terms land in one cycle (2*LANES-1 target positions, some summed); all arithmetic mod 2^Q_BITS.
- DRAIN: b_data = acc[b_cnt*LANES +: LANES], b_idx = b_cnt*LANES, b_last = (b_cnt == N/LANES-1). On handshake the drained chunk is cleared to zero, so acc is all-zero on return to LOAD_A.
- a_valid ignored outside LOAD_A; s_valid ignored outside MAC; b_ready ignored outside DRAIN.

## Timing
- Reset (rst_in low at a clk_in edge): state -> LOAD_A, counters and whole acc -> 0; s_ready=0, b_valid=0, b_data=0, b_idx=0, b_last=0, busy=0; a_ready=1 from first reset edge. Reset mid-MAC or mid-DRAIN discards all partial results.
- a_ready, s_ready, b_valid, b_last, busy decode state combinationally; acc is registered.
- s beat accepted at edge t updates acc at edge t; the next s beat (edge t+1) sees that value — full throughput, no overlap hazard between chunks j and j+1.
- A handshake at edge t -> s_ready=1 from t+1. Last s handshake at edge t -> b_valid=1 with final chunk 0 from t+1.
- Multiply latency: N²/LANES² s beats + N/LANES A beats; drain N/LANES beats when b_ready is held high.
- b_valid held and b_data/b_idx stable while b_ready low; no data loss under arbitrary backpressure.
- s_valid low in MAC stalls with no state change.

## Configuration
- POLY_NEGACYCLIC_EN defined: wrapped terms subtracted (x^N = -1), ring Z_q[x]/(x^N+1).
- Undefined: wrapped terms added (x^N = +1), cyclic convolution Z_q[x]/(x^N-1). All other behaviour identical.

## Test plan
Configuration for all: N=8, LANES=4, Q_BITS=6, S_BITS=1, POLY_NEGACYCLIC_EN defined unless stated.
- Identity: A = [1,0,0,0,0,0,0,0], s = [1,0,1,0,0,0,0,1] -> B = [1,0,1,0,0,0,0,1], b_idx 0 then 4, b_last on second beat.
- Wrap: A = x^7, s = x^1 -> B[0] = 63, all others 0; without macro B[0] = 1.
- Overflow: all A = 63, all s = 1 -> B[k] = (6-2k) mod 64 = [6,4,2,0,62,60,58,56].
- Backpressure: b_ready low 5 cycles at DRAIN entry -> b_valid stays 1, b_data = B[0..3], b_idx = 0 stable; then 2 beats, then a_ready=1.
- Reset mid-MAC after 3 s beats, then full identity run -> exact identity result, no residue.
- Back-to-back: overflow run then identity run -> second result exact (acc cleared by drain); s_valid pulsed in LOAD_A is ignored.

Source files
------------

// File: rtl/poly_negacyclic_mac_if.sv
// Stream bundle for poly_negacyclic_mac: A and s input streams, B result stream and busy flag.
// The design uses the slave modport; the producer/consumer side uses master.
interface poly_negacyclic_mac_if #(
  parameter int LANES  = 4,
  parameter int Q_BITS = 6,
  parameter int S_BITS = 1,
  parameter int CW     = 10
);
  logic                     a_valid;
  logic                     a_ready;
  logic [LANES*Q_BITS-1:0]  a_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [LANES*S_BITS-1:0]  s_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [LANES*Q_BITS-1:0]  b_data;
  logic [CW-1:0]            b_idx;
  logic                     b_last;
  logic                     busy;

  modport master (
    output a_valid, a_data, s_valid, s_data, b_ready,
    input  a_ready, s_ready, b_valid, b_data, b_idx, b_last, busy
  );

  modport slave (
    input  a_valid, a_data, s_valid, s_data, b_ready,
    output a_ready, s_ready, b_valid, b_data, b_idx, b_last, busy
  );
endinterface

// File: rtl/poly_negacyclic_mac.sv
// Streaming polynomial multiply-accumulate B = A*s mod (x^N +/- 1) mod 2^Q_BITS.
// Define POLY_NEGACYCLIC_EN for the negacyclic ring (x^N = -1); undefined gives cyclic (x^N = +1).
module poly_negacyclic_mac #(
  parameter int N      = 784,
  parameter int LANES  = 4,
  parameter int Q_BITS = 6,
  parameter int S_BITS = 1,
  parameter int CW     = $clog2(N)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  poly_negacyclic_mac_if.slave  bus
);
  localparam int NB    = N / LANES;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int KW    = CW + 1;
  localparam int DW    = 2 * LANES - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  typedef enum logic [1:0] {LOAD_A, MAC, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]        s_cnt_q, s_cnt_d;
  logic [CNT_W-1:0]        b_cnt_q, b_cnt_d;
  logic [LANES*Q_BITS-1:0] a_q, a_d;
  logic [Q_BITS-1:0]       acc_q [N];
  logic [Q_BITS-1:0]       acc_d [N];

  logic [Q_BITS-1:0]       term  [LANES][LANES];
  logic [Q_BITS-1:0]       delta [DW];
  logic                    wrap  [DW];
  logic [CW-1:0]           tgt_idx [DW];
  logic [KW-1:0]           base_sum;
  logic [CW-1:0]           b_base;

  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_p
      for (gj = 0; gj < LANES; gj++) begin : g_r
        assign term[gi][gj] = a_q[gi*Q_BITS +: Q_BITS] *
                              Q_BITS'(bus.s_data[gj*S_BITS +: S_BITS]);
      end
    end
  endgenerate

  // Terms sharing p+r land on the same coefficient, so pre-sum them by offset.
  always_comb begin
    for (int d = 0; d < DW; d++) delta[d] = '0;
    for (int p = 0; p < LANES; p++)
      for (int r = 0; r < LANES; r++)
        delta[p+r] = delta[p+r] + term[p][r];
  end

  assign base_sum = KW'(a_cnt_q) * KW'(LANES) + KW'(s_cnt_q) * KW'(LANES);

  generate
    for (gi = 0; gi < DW; gi++) begin : g_tgt
      logic [KW-1:0] k_sum;
      assign k_sum        = base_sum + KW'(gi);
      assign wrap[gi]     = (k_sum >= KW'(N));
      assign tgt_idx[gi]  = wrap[gi] ? CW'(k_sum - KW'(N)) : CW'(k_sum);
    end
  endgenerate

  assign b_base = CW'(b_cnt_q) * CW'(LANES);

  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    unique case (state_q)
      LOAD_A: begin
        if (bus.a_valid) begin
          a_d     = bus.a_data;
          state_d = MAC;
        end
      end
      MAC: begin
        if (bus.s_valid) begin
          for (int d = 0; d < DW; d++) begin
`ifdef POLY_NEGACYCLIC_EN
            if (wrap[d]) acc_d[tgt_idx[d]] = acc_d[tgt_idx[d]] - delta[d];
            else         acc_d[tgt_idx[d]] = acc_d[tgt_idx[d]] + delta[d];
`else
            acc_d[tgt_idx[d]] = acc_d[tgt_idx[d]] + delta[d];
`endif
          end
          if (s_cnt_q == LAST) begin
            s_cnt_d = '0;
            if (a_cnt_q == LAST) begin
              a_cnt_d = '0;
              state_d = DRAIN;
            end else begin
              a_cnt_d = a_cnt_q + 1'b1;
              state_d = LOAD_A;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.b_ready) begin
          // Clearing on drain leaves acc zeroed for the next multiplication.
          for (int l = 0; l < LANES; l++) acc_d[b_base + CW'(l)] = '0;
          if (b_cnt_q == LAST) begin
            b_cnt_d = '0;
            state_d = LOAD_A;
          end else begin
            b_cnt_d = b_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= LOAD_A;
      a_cnt_q <= '0;
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      a_q     <= '0;
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      s_cnt_q <= s_cnt_d;
      b_cnt_q <= b_cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.a_ready = (state_q == LOAD_A);
  assign bus.s_ready = (state_q == MAC);
  assign bus.b_valid = (state_q == DRAIN);
  assign bus.busy    = (state_q == MAC) || (state_q == DRAIN);
  assign bus.b_last  = (state_q == DRAIN) && (b_cnt_q == LAST);
  assign bus.b_idx   = (state_q == DRAIN) ? b_base : '0;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_bout
      assign bus.b_data[gi*Q_BITS +: Q_BITS] =
        (state_q == DRAIN) ? acc_q[b_base + CW'(gi)] : '0;
    end
  endgenerate
endmodule

// File: tb/tb_poly_negacyclic_mac.sv
// Scoreboard bench for poly_negacyclic_mac at N=8, LANES=4, Q_BITS=6, S_BITS=1.
// The reference model follows whichever ring POLY_NEGACYCLIC_EN selects.
module tb_poly_negacyclic_mac;
  localparam int N = 8, LANES = 4, QB = 6, SB = 1, CW = 3;
  localparam int NB = N / LANES;
  localparam int BW = LANES * QB;

  typedef struct {
    logic [BW-1:0] data;
    logic [CW-1:0] idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  beat_t sb[$];
  logic [N*QB-1:0] a_vec;
  logic [N*SB-1:0] s_vec;

  poly_negacyclic_mac_if #(.LANES(LANES), .Q_BITS(QB), .S_BITS(SB), .CW(CW)) ifc ();

  poly_negacyclic_mac #(.N(N), .LANES(LANES), .Q_BITS(QB), .S_BITS(SB), .CW(CW)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Direct O(N^2) polynomial product; expected beats go on the scoreboard.
  task automatic push_expected();
    int    acc [N];
    int    t, k;
    beat_t e;
    for (int k0 = 0; k0 < N; k0++) acc[k0] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        t = (int'(a_vec[i*QB +: QB]) * int'(s_vec[j*SB +: SB])) % 64;
        k = i + j;
        if (k < N) acc[k] = acc[k] + t;
`ifdef POLY_NEGACYCLIC_EN
        else acc[k-N] = acc[k-N] - t;
`else
        else acc[k-N] = acc[k-N] + t;
`endif
      end
    for (int b = 0; b < NB; b++) begin
      for (int l = 0; l < LANES; l++) e.data[l*QB +: QB] = QB'(acc[b*LANES+l] & 63);
      e.idx  = CW'(b * LANES);
      e.last = (b == NB - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_a(input int i);
    int cnt = 0;
    ifc.a_data  = a_vec[i*BW +: BW];
    ifc.a_valid = 1'b1;
    while (!ifc.a_ready && cnt < 50) begin tick(); cnt++; end
    check_val("a_ready_wait", {31'd0, ifc.a_ready}, 32'd1);
    tick();
    ifc.a_valid = 1'b0;
    check_val("s_ready_after_a", {31'd0, ifc.s_ready}, 32'd1);
  endtask

  task automatic drive_s(input int j);
    int cnt = 0;
    ifc.s_data  = s_vec[j*LANES*SB +: LANES*SB];
    ifc.s_valid = 1'b1;
    while (!ifc.s_ready && cnt < 50) begin tick(); cnt++; end
    check_val("s_ready_wait", {31'd0, ifc.s_ready}, 32'd1);
    tick();
    ifc.s_valid = 1'b0;
  endtask

  task automatic run_mac();
    push_expected();
    for (int i = 0; i < NB; i++) begin
      drive_a(i);
      for (int j = 0; j < NB; j++) drive_s(j);
    end
    check_val("b_valid_at_drain_entry", {31'd0, ifc.b_valid}, 32'd1);
  endtask

  task automatic drain(input int stall);
    beat_t e;
    int    cnt;
    ifc.b_ready = 1'b0;
    for (int c = 0; c < stall; c++) begin
      check_val("bp_b_valid", {31'd0, ifc.b_valid}, 32'd1);
      check_val("bp_b_data", {8'd0, ifc.b_data}, {8'd0, sb[0].data});
      check_val("bp_b_idx", {29'd0, ifc.b_idx}, 32'd0);
      tick();
    end
    ifc.b_ready = 1'b1;
    while (sb.size() > 0) begin
      cnt = 0;
      while (!ifc.b_valid && cnt < 50) begin tick(); cnt++; end
      check_val("b_valid_wait", {31'd0, ifc.b_valid}, 32'd1);
      e = sb.pop_front();
      $display("beat idx=%0d data=0x%06h last=%0b (expect idx=%0d data=0x%06h last=%0b)",
               ifc.b_idx, ifc.b_data, ifc.b_last, e.idx, e.data, e.last);
      check_val("b_data", {8'd0, ifc.b_data}, {8'd0, e.data});
      check_val("b_idx", {29'd0, ifc.b_idx}, {29'd0, e.idx});
      check_val("b_last", {31'd0, ifc.b_last}, {31'd0, e.last});
      tick();
    end
    ifc.b_ready = 1'b0;
    check_val("a_ready_after_drain", {31'd0, ifc.a_ready}, 32'd1);
    check_val("busy_after_drain", {31'd0, ifc.busy}, 32'd0);
  endtask

  task automatic set_identity();
    a_vec = '0;
    a_vec[0 +: QB] = QB'(1);
    s_vec = 8'b1000_0101;
  endtask

  initial begin
    ifc.a_valid = 1'b0; ifc.a_data = '0;
    ifc.s_valid = 1'b0; ifc.s_data = '0;
    ifc.b_ready = 1'b0;
    tick(); tick();
    check_val("rst_a_ready", {31'd0, ifc.a_ready}, 32'd1);
    check_val("rst_s_ready", {31'd0, ifc.s_ready}, 32'd0);
    check_val("rst_b_valid", {31'd0, ifc.b_valid}, 32'd0);
    check_val("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check_val("rst_b_data", {8'd0, ifc.b_data}, 32'd0);
    check_val("rst_b_idx", {29'd0, ifc.b_idx}, 32'd0);
    check_val("rst_b_last", {31'd0, ifc.b_last}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("txn: identity");
    set_identity();
    run_mac();
    drain(0);

    $display("txn: wrap x^7 * x^1");
    a_vec = '0; a_vec[7*QB +: QB] = QB'(1);
    s_vec = 8'b0000_0010;
    run_mac();
    drain(0);

    $display("txn: overflow with backpressure");
    a_vec = {N{6'd63}};
    s_vec = 8'hFF;
    run_mac();
    drain(5);

    $display("txn: s_valid pulsed in LOAD_A");
    ifc.s_data = 4'hF; ifc.s_valid = 1'b1;
    tick();
    check_val("load_a_s_ready", {31'd0, ifc.s_ready}, 32'd0);
    check_val("load_a_busy", {31'd0, ifc.busy}, 32'd0);
    tick();
    ifc.s_valid = 1'b0;

    $display("txn: identity back-to-back");
    set_identity();
    run_mac();
    drain(0);

    $display("txn: reset mid-MAC");
    a_vec = {N{6'd63}};
    s_vec = 8'hFF;
    drive_a(0); drive_s(0); drive_s(1);
    drive_a(1); drive_s(0);
    check_val("mid_mac_busy", {31'd0, ifc.busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_busy", {31'd0, ifc.busy}, 32'd0);
    check_val("mid_rst_a_ready", {31'd0, ifc.a_ready}, 32'd1);
    check_val("mid_rst_s_ready", {31'd0, ifc.s_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("txn: identity after reset");
    set_identity();
    run_mac();
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
